mem_access_unit: RTL and testbench

Load/store access unit between the EX/MEM pipeline register and the 64-bit, word-indexed data memory. It turns RISC-V byte-addressed loads and stores of any width into whole-doubleword memory accesses. Loads are extracted and sign- or zero-extended. Sub-word stores use a read-modify-write sequence, because the data memory only writes full 64-bit words. The unit stalls the pipeline until each access completes and flags misaligned or illegal accesses without touching memory.

---
 rtl/mem_access_if.sv | 41 ++++
 rtl/mem_access_unit.sv | 157 +++++++++++++++
 tb/tb_mem_access_unit.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// mem_access_if
//   Groups the EX/MEM request/response handshake and the data-memory bus
//   used by mem_access_unit.
//   slave  : the access unit (consumes requests and memory read data)
//   master : the pipeline/memory side (drives requests and memory read data)
// Signals
//   req_valid/req_load/req_store/req_funct3/req_addr/req_wdata : request
//   stall/done/load_data/misaligned                            : response
//   dm_address/dm_mem_read/dm_mem_write/dm_write_data          : memory cmd
//   dm_read_data                                                : memory data
interface mem_access_if;
  logic        req_valid;
  logic        req_load;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        stall;
  logic        done;
  logic [63:0] load_data;
  logic        misaligned;
  logic [63:0] dm_address;
  logic        dm_mem_read;
  logic        dm_mem_write;
  logic [63:0] dm_write_data;
  logic [63:0] dm_read_data;

  modport slave (
    input  req_valid, req_load, req_store, req_funct3, req_addr, req_wdata,
    input  dm_read_data,
    output stall, done, load_data, misaligned,
    output dm_address, dm_mem_read, dm_mem_write, dm_write_data
  );

  modport master (
    output req_valid, req_load, req_store, req_funct3, req_addr, req_wdata,
    output dm_read_data,
    input  stall, done, load_data, misaligned,
    input  dm_address, dm_mem_read, dm_mem_write, dm_write_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store unit between EX/MEM and a 64-bit word-indexed data memory.
//   Loads are extracted from the addressed doubleword and sign/zero extended.
//   SD writes directly; SB/SH/SW do a read-modify-write (read, then WRITE).
//   Misaligned or illegal ops are answered with misaligned=1 and no access.
// Ports
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : mem_access_if.slave (request, response and data-memory bus)
//
// state | meaning
// IDLE  | waiting; on accept drives the first dm access from the live request
// WRITE | sub-word store: writes the merged doubleword
// RESP  | done=1 for one cycle, stall released
module mem_access_unit (
  input  logic         clk,
  input  logic         reset,
  mem_access_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;

  state_t      state, state_n;
  logic [60:0] word_q;
  logic [63:0] merged_q;
  logic [63:0] load_q;
  logic        mis_q;

  logic        accept;
  logic        legal;
  logic [2:0]  offset;
  logic [63:0] shifted;
  logic [63:0] extracted;
  logic [7:0]  size_mask;
  logic [7:0]  byte_mask;
  logic [63:0] bit_mask;
  logic [63:0] wdata_sh;
  logic [63:0] merged;

  assign accept = bus.req_valid & (bus.req_load | bus.req_store);
  assign offset = bus.req_addr[2:0];

  always_comb begin
    legal = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b100: legal = 1'b1;
      3'b001, 3'b101: legal = (offset[0] == 1'b0);
      3'b010, 3'b110: legal = (offset[1:0] == 2'b00);
      3'b011:         legal = (offset == 3'b000);
      default:        legal = 1'b0;
    endcase
    // Unsigned widths only exist for loads.
    if (bus.req_store && bus.req_funct3[2])
      legal = 1'b0;
  end

  // Load extraction from the live read word.
  always_comb begin
    shifted   = bus.dm_read_data >> {offset, 3'b000};
    extracted = shifted;
    case (bus.req_funct3[1:0])
      2'b00:   extracted = bus.req_funct3[2] ? {56'd0, shifted[7:0]}
                                             : {{56{shifted[7]}}, shifted[7:0]};
      2'b01:   extracted = bus.req_funct3[2] ? {48'd0, shifted[15:0]}
                                             : {{48{shifted[15]}}, shifted[15:0]};
      2'b10:   extracted = bus.req_funct3[2] ? {32'd0, shifted[31:0]}
                                             : {{32{shifted[31]}}, shifted[31:0]};
      default: extracted = shifted;
    endcase
  end

  // Store merge: replace the addressed byte lanes of the read word.
  always_comb begin
    case (bus.req_funct3[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
    byte_mask = size_mask << offset;
    bit_mask  = '0;
    for (int i = 0; i < 8; i++)
      bit_mask[8*i +: 8] = {8{byte_mask[i]}};
    wdata_sh = bus.req_wdata << {offset, 3'b000};
    merged   = (bus.dm_read_data & ~bit_mask) | (wdata_sh & bit_mask);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q   <= '0;
      merged_q <= '0;
      load_q   <= '0;
      mis_q    <= 1'b0;
    end else if (state == IDLE && accept) begin
      word_q   <= bus.req_addr[63:3];
      merged_q <= merged;
      load_q   <= (legal && !bus.req_store) ? extracted : 64'd0;
      mis_q    <= ~legal;
    end
  end

  always_comb begin
    state_n           = state;
    bus.stall         = 1'b0;
    bus.done          = 1'b0;
    bus.dm_address    = '0;
    bus.dm_mem_read   = 1'b0;
    bus.dm_mem_write  = 1'b0;
    bus.dm_write_data = '0;
    // The IDLE path is driven from the live request, so reset must mask it.
    if (!reset) begin
      case (state)
        IDLE: begin
          if (accept) begin
            bus.stall = 1'b1;
            state_n   = RESP;
            if (legal) begin
              bus.dm_address = {3'b000, bus.req_addr[63:3]};
              if (bus.req_store && bus.req_funct3[1:0] == 2'b11) begin
                bus.dm_mem_write  = 1'b1;
                bus.dm_write_data = bus.req_wdata;
              end else if (bus.req_store) begin
                bus.dm_mem_read = 1'b1;
                state_n         = WRITE;
              end else begin
                bus.dm_mem_read = 1'b1;
              end
            end
          end
        end
        WRITE: begin
          bus.stall         = 1'b1;
          bus.dm_mem_write  = 1'b1;
          bus.dm_address    = {3'b000, word_q};
          bus.dm_write_data = merged_q;
          state_n           = RESP;
        end
        RESP: begin
          bus.done = 1'b1;
          state_n  = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.load_data  = (state == RESP) ? load_q : 64'd0;
  assign bus.misaligned = (state == RESP) & mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_access_if bus();

  mem_access_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [63:0] mem [0:15];
  int n_checks = 0;
  int n_fail   = 0;
  int total_writes = 0;

  assign bus.dm_read_data = mem[bus.dm_address[3:0]];

  always @(posedge clk) begin
    if (bus.dm_mem_write) begin
      mem[bus.dm_address[3:0]] <= bus.dm_write_data;
      total_writes++;
    end
  end

  // Result of the last run_op.
  int          r_lat, r_stalls, r_writes, r_reads, r_wcyc;
  logic [63:0] r_data;
  logic        r_mis;

  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wd);
    r_lat = 0; r_stalls = 0; r_writes = 0; r_reads = 0; r_wcyc = 0;
    r_data = 'x; r_mis = 1'bx;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_load = ld; bus.req_store = st;
    bus.req_funct3 = f3; bus.req_addr = addr; bus.req_wdata = wd;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (bus.stall) r_stalls++;
      if (bus.dm_mem_write) begin r_writes++; r_wcyc = cyc; end
      if (bus.dm_mem_read) r_reads++;
      if (bus.done) begin
        r_lat = cyc; r_data = bus.load_data; r_mis = bus.misaligned;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_load = 1'b0; bus.req_store = 1'b0;
  endtask

  task automatic test_reset;
    n_checks++;
    if ({bus.stall, bus.done, bus.misaligned, bus.dm_mem_read, bus.dm_mem_write} !== 5'b0 ||
        bus.load_data !== 64'd0 || bus.dm_address !== 64'd0 || bus.dm_write_data !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: stall=%b done=%b mis=%b rd=%b wr=%b ld=%h addr=%h wd=%h, required all 0",
               bus.stall, bus.done, bus.misaligned, bus.dm_mem_read, bus.dm_mem_write,
               bus.load_data, bus.dm_address, bus.dm_write_data);
    end
  endtask

  task automatic test_byte_loads;
    run_op(1, 0, 3'b000, 64'h0F, 64'd0);
    n_checks++;
    if (r_data !== 64'hFFFFFFFFFFFFFF88) begin
      n_fail++; $display("FAIL lb_data: got %h required %h", r_data, 64'hFFFFFFFFFFFFFF88);
    end
    n_checks++;
    if (r_lat !== 2 || r_stalls !== 1 || r_reads !== 1 || r_writes !== 0) begin
      n_fail++;
      $display("FAIL lb_timing: lat=%0d stalls=%0d reads=%0d writes=%0d required 2/1/1/0",
               r_lat, r_stalls, r_reads, r_writes);
    end
    run_op(1, 0, 3'b100, 64'h0F, 64'd0);
    n_checks++;
    if (r_data !== 64'h88 || r_lat !== 2 || r_stalls !== 1 || r_mis !== 1'b0) begin
      n_fail++;
      $display("FAIL lbu: data=%h lat=%0d stalls=%0d mis=%b required 88/2/1/0",
               r_data, r_lat, r_stalls, r_mis);
    end
  endtask

  task automatic test_subword_store;
    int w0;
    w0 = total_writes;
    run_op(0, 1, 3'b001, 64'h0A, 64'h1234_5678_9ABC_BEEF);
    n_checks++;
    if (mem[1] !== 64'h88776655BEEF2211) begin
      n_fail++; $display("FAIL sh_word: got %h required %h", mem[1], 64'h88776655BEEF2211);
    end
    n_checks++;
    if (r_writes !== 1 || r_wcyc !== 2 || r_lat !== 3 || r_stalls !== 2 || total_writes - w0 !== 1) begin
      n_fail++;
      $display("FAIL sh_timing: writes=%0d wcyc=%0d lat=%0d stalls=%0d required 1/2/3/2",
               r_writes, r_wcyc, r_lat, r_stalls);
    end
    run_op(1, 0, 3'b001, 64'h0E, 64'd0);
    n_checks++;
    if (r_data !== 64'hFFFFFFFFFFFF8877) begin
      n_fail++; $display("FAIL lh_after_sh: got %h required %h", r_data, 64'hFFFFFFFFFFFF8877);
    end
  endtask

  task automatic test_misaligned;
    int w0;
    w0 = total_writes;
    run_op(1, 0, 3'b010, 64'h0A, 64'd0);
    n_checks++;
    if (r_mis !== 1'b1 || r_lat !== 2 || r_data !== 64'd0 || r_reads !== 0 || r_writes !== 0) begin
      n_fail++;
      $display("FAIL lw_misaligned: mis=%b lat=%0d data=%h reads=%0d writes=%0d required 1/2/0/0/0",
               r_mis, r_lat, r_data, r_reads, r_writes);
    end
    run_op(0, 1, 3'b100, 64'h08, 64'hFF);
    n_checks++;
    if (r_mis !== 1'b1 || r_writes !== 0 || r_reads !== 0 || mem[1] !== 64'h88776655BEEF2211) begin
      n_fail++;
      $display("FAIL store_unsigned_illegal: mis=%b writes=%0d reads=%0d word1=%h", r_mis, r_writes, r_reads, mem[1]);
    end
    run_op(1, 0, 3'b111, 64'h00, 64'd0);
    n_checks++;
    if (r_mis !== 1'b1 || r_reads !== 0 || total_writes !== w0) begin
      n_fail++; $display("FAIL funct3_111: mis=%b reads=%0d, required 1/0", r_mis, r_reads);
    end
  endtask

  task automatic test_back_to_back;
    run_op(0, 1, 3'b011, 64'h60, 64'h0123456789ABCDEF);
    n_checks++;
    if (mem[12] !== 64'h0123456789ABCDEF || r_wcyc !== 1 || r_lat !== 2 || r_stalls !== 1 || r_reads !== 0) begin
      n_fail++;
      $display("FAIL sd: word12=%h wcyc=%0d lat=%0d stalls=%0d reads=%0d", mem[12], r_wcyc, r_lat, r_stalls, r_reads);
    end
    run_op(1, 0, 3'b011, 64'h60, 64'd0);
    n_checks++;
    if (r_data !== 64'h0123456789ABCDEF) begin
      n_fail++; $display("FAIL ld: got %h required %h", r_data, 64'h0123456789ABCDEF);
    end
    run_op(1, 0, 3'b110, 64'h64, 64'd0);
    n_checks++;
    if (r_data !== 64'h0000000001234567) begin
      n_fail++; $display("FAIL lwu: got %h required %h", r_data, 64'h0000000001234567);
    end
  endtask

  task automatic test_reset_mid_write;
    int w0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_load = 1'b0; bus.req_store = 1'b1;
    bus.req_funct3 = 3'b010; bus.req_addr = 64'h10; bus.req_wdata = 64'hDEADBEEF;
    @(posedge clk);
    w0 = total_writes;
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (bus.dm_mem_write !== 1'b0 || bus.stall !== 1'b0 || bus.dm_mem_read !== 1'b0 ||
        bus.dm_address !== 64'd0 || bus.dm_write_data !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: wr=%b stall=%b rd=%b addr=%h wd=%h required 0",
               bus.dm_mem_write, bus.stall, bus.dm_mem_read, bus.dm_address, bus.dm_write_data);
    end
    bus.req_valid = 1'b0; bus.req_store = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (total_writes !== w0 || mem[2] !== 64'hAAAA_BBBB_CCCC_DDDD) begin
      n_fail++; $display("FAIL reset_no_write: writes=%0d word2=%h required %0d/aaaabbbbccccdddd",
                         total_writes, mem[2], w0);
    end
    run_op(1, 0, 3'b011, 64'h10, 64'd0);
    n_checks++;
    if (r_lat !== 2 || r_data !== 64'hAAAA_BBBB_CCCC_DDDD) begin
      n_fail++; $display("FAIL reset_idle_after: lat=%0d data=%h required 2/aaaabbbbccccdddd", r_lat, r_data);
    end
  endtask

  task automatic test_no_op;
    int bad;
    bad = 0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_load = 1'b0; bus.req_store = 1'b0;
    bus.req_addr = 64'h08; bus.req_funct3 = 3'b011;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.stall || bus.done || bus.dm_mem_read || bus.dm_mem_write) bad++;
    end
    bus.req_valid = 1'b0;
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL no_op: %0d active cycles, required 0", bad);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 64'd0;
    mem[1] = 64'h8877665544332211;
    mem[2] = 64'hAAAA_BBBB_CCCC_DDDD;
    bus.req_valid = 1'b0; bus.req_load = 1'b0; bus.req_store = 1'b0;
    bus.req_funct3 = 3'b000; bus.req_addr = '0; bus.req_wdata = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    reset = 1'b0;
    test_byte_loads;
    test_subword_store;
    test_misaligned;
    test_back_to_back;
    test_reset_mid_write;
    test_no_op;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
